lathe_star_delta_seq: RTL and testbench

//  Spindle-motor contactor sequencer sitting directly downstream of the lathe PLC control block.

---
 rtl/lathe_star_delta_seq.sv | 127 ++++++++++++
 tb/tb_lathe_star_delta_seq.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/lathe_star_delta_seq.sv
// Star-delta spindle contactor sequencer: star start, dead-time transfer, delta run,
// latched overload/E-stop trip and restart lockout.
module lathe_star_delta_seq #(
    parameter int STAR_TIME    = 20,
    parameter int DEAD_TIME    = 4,
    parameter int MIN_OFF_TIME = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ena,
    input  logic       run_req,
    input  logic       ovl_n,
    input  logic       estop,
    input  logic       fault_ack,
    output logic       k_main,
    output logic       k_star,
    output logic       k_delta,
    output logic       running,
    output logic       fault,
    output logic [2:0] state_o
);

    localparam int MAX_T = (STAR_TIME > DEAD_TIME)
                         ? ((STAR_TIME > MIN_OFF_TIME) ? STAR_TIME : MIN_OFF_TIME)
                         : ((DEAD_TIME > MIN_OFF_TIME) ? DEAD_TIME : MIN_OFF_TIME);
    localparam int CW = $clog2(MAX_T) + 1;

    localparam logic [CW-1:0] STAR_LAST = CW'(STAR_TIME - 1);
    localparam logic [CW-1:0] DEAD_LAST = CW'(DEAD_TIME - 1);
    localparam logic [CW-1:0] OFF_LAST  = CW'(MIN_OFF_TIME - 1);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        STAR     = 3'd1,
        TRANSFER = 3'd2,
        DELTA    = 3'd3,
        LOCKOUT  = 3'd4,
        FAULT    = 3'd5
    } state_t;

    logic run_meta, run_s;
    logic ovl_meta, ovl_s;
    logic estop_meta, estop_s;
    logic ack_meta, ack_s, ack_d;

    state_t        state, state_nxt;
    logic [CW-1:0] cnt, cnt_nxt;
    logic          trip, ack_rise, timed;

    // Overload contact is normally closed, so its synchronizer idles high.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            run_meta   <= 1'b0;
            run_s      <= 1'b0;
            ovl_meta   <= 1'b1;
            ovl_s      <= 1'b1;
            estop_meta <= 1'b0;
            estop_s    <= 1'b0;
            ack_meta   <= 1'b0;
            ack_s      <= 1'b0;
            ack_d      <= 1'b0;
        end else begin
            run_meta   <= run_req;
            run_s      <= run_meta;
            ovl_meta   <= ovl_n;
            ovl_s      <= ovl_meta;
            estop_meta <= estop;
            estop_s    <= estop_meta;
            ack_meta   <= fault_ack;
            ack_s      <= ack_meta;
            ack_d      <= ack_s;
        end
    end

    assign trip     = ~ovl_s | estop_s;
    assign ack_rise = ack_s & ~ack_d;
    assign timed    = (state == STAR) || (state == TRANSFER) || (state == LOCKOUT);

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        if (trip) begin
            state_nxt = FAULT;
        end else if (ena) begin
            case (state)
                IDLE:     if (run_s) state_nxt = STAR;
                STAR:     if (!run_s) state_nxt = LOCKOUT;
                          else if (cnt == STAR_LAST) state_nxt = TRANSFER;
                TRANSFER: if (!run_s) state_nxt = LOCKOUT;
                          else if (cnt == DEAD_LAST) state_nxt = DELTA;
                DELTA:    if (!run_s) state_nxt = LOCKOUT;
                LOCKOUT:  if (cnt == OFF_LAST) state_nxt = IDLE;
                FAULT:    if (ack_rise && !run_s) state_nxt = LOCKOUT;
                default:  state_nxt = IDLE;
            endcase
        end
        // Timer restarts on every state change and is frozen while ena is low.
        if (state_nxt != state) begin
            cnt_nxt = '0;
        end else if (ena && timed) begin
            cnt_nxt = cnt + CW'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            cnt     <= '0;
            k_main  <= 1'b0;
            k_star  <= 1'b0;
            k_delta <= 1'b0;
            running <= 1'b0;
            fault   <= 1'b0;
        end else begin
            state   <= state_nxt;
            cnt     <= cnt_nxt;
            k_main  <= (state_nxt == STAR) || (state_nxt == TRANSFER) || (state_nxt == DELTA);
            k_star  <= (state_nxt == STAR);
            k_delta <= (state_nxt == DELTA);
            running <= (state_nxt == DELTA);
            fault   <= (state_nxt == FAULT);
        end
    end

    assign state_o = state;

endmodule

// File: tb/tb_lathe_star_delta_seq.sv
// Scoreboard bench for lathe_star_delta_seq: directed sequences plus random stimulus
// checked against a cycle-level reference model and contactor safety invariants.
module tb_lathe_star_delta_seq;

    localparam int ST = 10;
    localparam int DT = 3;
    localparam int MO = 5;

    typedef struct packed {
        logic run;
        logic ovl_n;
        logic estop;
        logic ack;
        logic ena;
    } in_t;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       ena = 1'b1;
    logic       run_req = 1'b0;
    logic       ovl_n = 1'b1;
    logic       estop = 1'b0;
    logic       fault_ack = 1'b0;
    logic       k_main, k_star, k_delta, running, fault;
    logic [2:0] state_o;

    lathe_star_delta_seq #(.STAR_TIME(ST), .DEAD_TIME(DT), .MIN_OFF_TIME(MO)) dut (
        .clk(clk), .reset(reset), .ena(ena), .run_req(run_req), .ovl_n(ovl_n),
        .estop(estop), .fault_ack(fault_ack), .k_main(k_main), .k_star(k_star),
        .k_delta(k_delta), .running(running), .fault(fault), .state_o(state_o)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    logic [7:0] exp_q[$];

    // Reference model: phase numbers follow the published state_o encoding.
    in_t hist[$];
    int  m_phase;
    int  m_elapsed;

    task automatic check(input string name, input logic [7:0] got, input logic [7:0] req);
        n_cmp++;
        if (got !== req) begin
            n_bad++;
            $display("FAIL %s: got %h required %h at %0t", name, got, req, $time);
        end
    endtask

    function automatic logic [7:0] expect_of(input int ph);
        logic on;
        on = (ph == 1) || (ph == 2) || (ph == 3);
        return {on, ph == 1, ph == 3, ph == 3, ph == 5, 3'(ph)};
    endfunction

    task automatic model_reset();
        in_t idle_in;
        idle_in = '{run: 1'b0, ovl_n: 1'b1, estop: 1'b0, ack: 1'b0, ena: 1'b0};
        hist.delete();
        repeat (4) hist.push_back(idle_in);
        m_phase   = 0;
        m_elapsed = 0;
    endtask

    // Controller sees inputs two edges old; acknowledge edge compares two consecutive old samples.
    task automatic model_edge(input in_t cur);
        in_t s, p;
        int  nxt;
        logic rise, trip;
        hist.push_front(cur);
        s    = hist[2];
        p    = hist[3];
        rise = s.ack && !p.ack;
        trip = !s.ovl_n || s.estop;
        nxt  = m_phase;
        if (trip) nxt = 5;
        else if (cur.ena) begin
            case (m_phase)
                0: if (s.run) nxt = 1;
                1: if (!s.run) nxt = 4; else if (m_elapsed + 1 == ST) nxt = 2;
                2: if (!s.run) nxt = 4; else if (m_elapsed + 1 == DT) nxt = 3;
                3: if (!s.run) nxt = 4;
                4: if (m_elapsed + 1 == MO) nxt = 0;
                5: if (rise && !s.run) nxt = 4;
                default: nxt = 0;
            endcase
        end
        if (nxt != m_phase) begin
            m_phase   = nxt;
            m_elapsed = 0;
        end else if (cur.ena) begin
            m_elapsed++;
        end
        void'(hist.pop_back());
    endtask

    task automatic step();
        in_t v;
        v = {run_req, ovl_n, estop, fault_ack, ena};
        @(posedge clk);
        if (reset) model_reset();
        else model_edge(v);
        exp_q.push_back(expect_of(m_phase));
        #3;
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    // Monitor: outputs are presented every cycle; compare against the queued prediction.
    int   star_off = 0;
    logic delta_prev = 1'b0;
    always begin
        @(posedge clk);
        #2;
        if (exp_q.size() > 0) begin
            check("outputs", {k_main, k_star, k_delta, running, fault, state_o}, exp_q.pop_front());
            check("star_delta_exclusive", {7'd0, k_star & k_delta}, 8'd0);
            check("coil_without_main", {7'd0, (k_star | k_delta) & ~k_main}, 8'd0);
            if (k_delta && !delta_prev)
                check("dead_time_before_delta", {7'd0, star_off < DT}, 8'd0);
        end
        star_off   = k_star ? 0 : star_off + 1;
        delta_prev = k_delta;
    end

    initial begin
        model_reset();
        steps(3);
        reset = 1'b0;
        steps(2);

        // Start to DELTA, then drop and re-raise during lockout.
        run_req = 1'b1;
        steps(20);
        run_req = 1'b0;
        steps(5);
        run_req = 1'b1;
        steps(22);

        // Asynchronous reset while running in delta.
        reset = 1'b1;
        #1;
        check("reset_async", {k_main, k_star, k_delta, running, fault, state_o}, 8'd0);
        run_req = 1'b0;
        steps(2);
        reset = 1'b0;
        steps(6);

        // Overload trip in STAR, ignored ack, valid ack.
        run_req = 1'b1;
        steps(6);
        ovl_n = 1'b0;
        steps(5);
        ovl_n = 1'b1;
        steps(3);
        fault_ack = 1'b1;
        steps(2);
        fault_ack = 1'b0;
        steps(4);
        run_req = 1'b0;
        steps(4);
        fault_ack = 1'b1;
        steps(2);
        fault_ack = 1'b0;
        steps(10);

        // Freeze in TRANSFER, E-stop still trips.
        run_req = 1'b1;
        steps(13);
        ena = 1'b0;
        steps(6);
        estop = 1'b1;
        steps(5);
        estop = 1'b0;
        ena = 1'b1;
        run_req = 1'b0;
        steps(3);
        fault_ack = 1'b1;
        steps(2);
        fault_ack = 1'b0;
        steps(10);

        // Random stimulus on every input.
        for (int i = 0; i < 10000; i++) begin
            if ($urandom_range(39) == 0) run_req = ~run_req;
            if (ovl_n) ovl_n = ($urandom_range(299) != 0);
            else ovl_n = ($urandom_range(9) == 0);
            if (!estop) estop = ($urandom_range(299) == 0);
            else estop = ($urandom_range(9) != 0);
            fault_ack = ($urandom_range(7) == 0);
            ena = ($urandom_range(9) != 0);
            if (reset) reset = 1'b0;
            else reset = ($urandom_range(1999) == 0);
            step();
        end
        reset = 1'b0;
        steps(2);

        for (int i = 0; i < 5 && exp_q.size() > 0; i++) @(posedge clk);
        #3;
        check("queue_drained", 8'(exp_q.size()), 8'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
